// File: rtl/psram_cmd_queue_pkg.sv
// Shared types for the PSRAM command queue: request entry, FSM states,
// and the controller address width.
package psram_pkg;

  localparam int PS_ADDR_W = 25;

  typedef struct packed {
    logic                 write;
    logic [PS_ADDR_W-1:0] addr;   // byte address bits [26:2]
    logic [31:0]          wdata;
    logic [3:0]           wbe;
  } psram_req_t;

  typedef enum logic {
    ST_IDLE,
    ST_WAIT_RD
  } psram_state_t;

endpackage

// File: rtl/psram_cmd_queue_if.sv
// Client request/response port plus the ps_* controller command port.
// slave = queue side, master = client/controller model side.
interface psram_cmd_queue_if;
  import psram_pkg::*;

  logic                 req_valid;
  logic                 req_ready;
  logic                 req_write;
  logic [PS_ADDR_W-1:0] req_addr;
  logic [31:0]          req_wdata;
  logic [3:0]           req_wbe;

  logic                 rsp_valid;
  logic [31:0]          rsp_rdata;

  logic [PS_ADDR_W-1:0] ps_addr;
  logic                 ps_re;
  logic                 ps_we;
  logic                 ps_refresh;
  logic [31:0]          ps_wdata;
  logic [3:0]           ps_wbe;
  logic                 ps_cmdready;
  logic [31:0]          ps_rdata;
  logic                 ps_rdready;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_wbe,
    input  ps_cmdready, ps_rdata, ps_rdready,
    output req_ready, rsp_valid, rsp_rdata,
    output ps_addr, ps_re, ps_we, ps_refresh, ps_wdata, ps_wbe
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_wbe,
    output ps_cmdready, ps_rdata, ps_rdready,
    input  req_ready, rsp_valid, rsp_rdata,
    input  ps_addr, ps_re, ps_we, ps_refresh, ps_wdata, ps_wbe
  );

endinterface

// File: rtl/psram_cmd_queue_fifo.sv
// Small in-order request FIFO. Flags derive from a registered occupancy
// count, so full never depends combinationally on a same-cycle pop.
// Head is read straight out of the storage registers.
module psram_req_fifo
  import psram_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk100m,
  input  logic       phy_rst,
  input  logic       push,
  input  psram_req_t din,
  input  logic       pop,
  output psram_req_t head,
  output logic       empty,
  output logic       full
);

  localparam int AW = $clog2(DEPTH);

  psram_req_t      mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));

  // storage write; contents are don't-care until count covers them
  always_ff @(posedge clk100m) begin
    if (push) mem[wr_ptr] <= din;
  end

  // pointers and occupancy; callers never push when full or pop when empty
  always_ff @(posedge clk100m or posedge phy_rst) begin
    if (phy_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/psram_cmd_queue.sv
// PSRAM request queue and refresh scheduler.
// Buffers client requests, issues them in order on ps_*, tracks one
// outstanding read and returns its data as a one-cycle pulse.
// Build option: define PSRAM_CMDQ_REFRESH_EN to include the periodic
// refresh counter, pending count and sticky refresh_overrun.
module psram_cmd_queue
  import psram_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int REFI_CYCLES  = 780,
  parameter int MAX_POSTPONE = 8
) (
  input  logic               clk100m,
  input  logic               phy_rst,
  psram_cmd_queue_if.slave   bus,
  output logic               refresh_overrun
);

  psram_req_t   enq_req;
  psram_req_t   head;
  psram_state_t state;
  logic         fifo_full;
  logic         fifo_empty;
  logic         push;
  logic         pop;
  logic         accept;
  logic         ref_pend;
  logic         rd_prev;
  logic         rd_rise;

  assign enq_req = '{write: bus.req_write, addr: bus.req_addr,
                     wdata: bus.req_wdata, wbe: bus.req_wbe};

  assign bus.req_ready = ~fifo_full;
  assign push          = bus.req_valid & ~fifo_full;
  assign accept        = bus.ps_cmdready & (bus.ps_re | bus.ps_we | bus.ps_refresh);
  assign pop           = accept & (bus.ps_re | bus.ps_we);
  assign rd_rise       = bus.ps_rdready & ~rd_prev;

  psram_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk100m (clk100m),
    .phy_rst (phy_rst),
    .push    (push),
    .din     (enq_req),
    .pop     (pop),
    .head    (head),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  // command decode: refresh beats the FIFO head; nothing issued while a read is in flight
  always_comb begin
    bus.ps_re      = 1'b0;
    bus.ps_we      = 1'b0;
    bus.ps_refresh = 1'b0;
    bus.ps_addr    = '0;
    bus.ps_wdata   = '0;
    bus.ps_wbe     = '0;
    if (state == ST_IDLE) begin
      if (ref_pend) begin
        bus.ps_refresh = 1'b1;
      end else if (!fifo_empty) begin
        bus.ps_re    = ~head.write;
        bus.ps_we    = head.write;
        bus.ps_addr  = head.addr;
        bus.ps_wdata = head.wdata;
        bus.ps_wbe   = head.wbe;
      end
    end
  end

  // issue FSM and read-return capture; ps_rdready edges outside WAIT_RD are ignored
  always_ff @(posedge clk100m or posedge phy_rst) begin
    if (phy_rst) begin
      state         <= ST_IDLE;
      rd_prev       <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
    end else begin
      rd_prev       <= bus.ps_rdready;
      bus.rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept && bus.ps_re) state <= ST_WAIT_RD;
        end
        ST_WAIT_RD: begin
          if (rd_rise) begin
            state         <= ST_IDLE;
            bus.rsp_valid <= 1'b1;
            bus.rsp_rdata <= bus.ps_rdata;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef PSRAM_CMDQ_REFRESH_EN
  localparam int RW = (REFI_CYCLES > 1) ? $clog2(REFI_CYCLES) : 1;
  localparam int PW = $clog2(MAX_POSTPONE + 2);
  localparam logic [RW-1:0] REFI_RELOAD = RW'(REFI_CYCLES - 1);
  localparam logic [PW-1:0] PEND_MAX    = PW'(MAX_POSTPONE + 1);

  logic [RW-1:0] refi_cnt;
  logic [PW-1:0] pend;
  logic [PW-1:0] pend_nxt;
  logic          refi_tick;
  logic          ref_acc;

  assign refi_tick = (refi_cnt == '0);
  assign ref_acc   = accept & bus.ps_refresh;
  assign ref_pend  = (pend != '0);

  // pending count: a tick and an accept in the same cycle cancel out
  always_comb begin
    pend_nxt = pend;
    if (refi_tick && !ref_acc && pend != PEND_MAX) pend_nxt = pend + 1'b1;
    else if (ref_acc && !refi_tick)                pend_nxt = pend - 1'b1;
  end

  // refresh interval down-counter
  always_ff @(posedge clk100m or posedge phy_rst) begin
    if (phy_rst) refi_cnt <= REFI_RELOAD;
    else         refi_cnt <= refi_tick ? REFI_RELOAD : refi_cnt - 1'b1;
  end

  // pending refreshes and sticky overrun flag
  always_ff @(posedge clk100m or posedge phy_rst) begin
    if (phy_rst) begin
      pend            <= '0;
      refresh_overrun <= 1'b0;
    end else begin
      pend <= pend_nxt;
      if (pend_nxt == PEND_MAX) refresh_overrun <= 1'b1;
    end
  end
`else
  logic unused_refresh_cfg;

  assign ref_pend           = 1'b0;
  assign refresh_overrun    = 1'b0;
  assign unused_refresh_cfg = ^{REFI_CYCLES, MAX_POSTPONE};
`endif

endmodule
